m_code_31_sync: RTL and testbench

// - Receive end of the 31-chip m-sequence link: recovers chip timing from serial rx_code (16 clk/chip).
// - Runs a local 5-stage LFSR and slips it one chip per failed window until correlation locks.
// - Then tracks the code and drops lock on sustained loss.
// - Sits after the m-code channel; locked/local_code feed downstream despreading.

---
 rtl/m_code_pkg.sv | 16 +
 rtl/m_code_lfsr5.sv | 29 ++
 rtl/m_code_31_sync.sv | 177 +++++++++++++++++
 tb/tb_m_code_31_sync.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/m_code_pkg.sv
// rtl/m_code_pkg.sv - shared m-sequence constants, LFSR step and sync state type
package m_code_pkg;

    localparam logic [4:0] M_SEED = 5'b11111;
    localparam int         M_LEN  = 31;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } msync_state_e;

    function automatic logic [4:0] m_next(input logic [4:0] q);
        return {q[3] ^ q[0], q[4:1]};
    endfunction

endpackage

// File: rtl/m_code_lfsr5.sv
// rtl/m_code_lfsr5.sv - 5-stage m-sequence LFSR with advance enable, hold and seed reload
module m_code_lfsr5
    import m_code_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic       i_hold,
    input  logic       i_load,
    output logic [4:0] o_q,
    output logic       o_chip
);

    logic [4:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= M_SEED;
        end else if (i_load) begin
            r_q <= M_SEED;
        end else if (i_en && !i_hold) begin
            r_q <= m_next(r_q);
        end
    end

    assign o_q    = r_q;
    assign o_chip = r_q[0];

endmodule

// File: rtl/m_code_31_sync.sv
// rtl/m_code_31_sync.sv - 31-chip m-code chip-timing recovery, sliding correlator and lock FSM
// Build option MSYNC_BER_EN: enables the saturating chip-error counter on err_cnt.
module m_code_31_sync
    import m_code_pkg::*;
#(
    parameter int CLK_PER_CHIP = 16,
    parameter int SAMPLE_PH    = 8,
    parameter int LOCK_TH      = 28,
    parameter int LOSS_TH      = 24,
    parameter int MISS_MAX     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_code,
    output logic        locked,
    output logic        local_code,
    output logic [4:0]  corr_val,
    output logic        corr_valid,
    output logic [4:0]  slip_cnt,
    output logic [15:0] err_cnt
);

    localparam int              PH_W        = $clog2(CLK_PER_CHIP);
    localparam logic [PH_W-1:0] C_SAMPLE_PH = PH_W'(SAMPLE_PH);
    localparam logic [4:0]      C_LOCK_TH   = 5'(LOCK_TH);
    localparam logic [4:0]      C_LOSS_TH   = 5'(LOSS_TH);
    localparam logic [1:0]      C_MISS_MAX  = 2'(MISS_MAX);
    localparam logic [4:0]      C_LAST      = 5'(M_LEN - 1);

    logic            r_rx_d;
    logic [PH_W-1:0] r_phase;
    logic [4:0]      r_win_idx;
    logic [4:0]      r_matches;
    logic [4:0]      r_corr_val;
    logic            r_corr_valid;
    logic [1:0]      r_miss;
    logic            r_slip_pend;
    logic [4:0]      r_slip_cnt;
    msync_state_e    r_state;

    msync_state_e    w_state_nxt;
    logic            w_edge;
    logic            w_strobe;
    logic            w_match;
    logic [4:0]      w_corr;
    logic            w_win_end;
    logic            w_pass_lock;
    logic            w_pass_loss;
    logic [1:0]      w_miss_inc;
    logic            w_enter_locked;
    logic            w_enter_search;
    logic [4:0]      w_q;
    logic            w_chip;
    logic            w_lfsr_zero;

    // An rx transition re-centres chip timing and suppresses a coincident sample.
    assign w_edge      = (rx_code != r_rx_d);
    assign w_strobe    = (r_phase == C_SAMPLE_PH) && !w_edge;
    assign w_match     = (r_rx_d == w_chip);
    assign w_corr      = r_matches + {4'd0, w_match};
    assign w_win_end   = w_strobe && (r_win_idx == C_LAST);
    assign w_pass_lock = (w_corr >= C_LOCK_TH);
    assign w_pass_loss = (w_corr >= C_LOSS_TH);
    assign w_miss_inc  = r_miss + 2'd1;
    assign w_lfsr_zero = (w_q == 5'd0);

    assign w_enter_locked = (r_state == SEARCH) && (w_state_nxt == LOCKED);
    assign w_enter_search = (r_state == LOCKED) && (w_state_nxt == SEARCH);

    m_code_lfsr5 u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_strobe),
        .i_hold (r_slip_pend),
        .i_load (w_lfsr_zero),
        .o_q    (w_q),
        .o_chip (w_chip)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_d  <= 1'b1;
            r_phase <= '0;
        end else begin
            r_rx_d  <= rx_code;
            r_phase <= w_edge ? '0 : r_phase + PH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_idx    <= '0;
            r_matches    <= '0;
            r_corr_val   <= '0;
            r_corr_valid <= 1'b0;
        end else begin
            r_corr_valid <= w_win_end;
            if (w_win_end) begin
                r_win_idx  <= '0;
                r_matches  <= '0;
                r_corr_val <= w_corr;
            end else if (w_strobe) begin
                r_win_idx <= r_win_idx + 5'd1;
                r_matches <= w_corr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_win_end) begin
            case (r_state)
                SEARCH:  if (w_pass_lock) w_state_nxt = LOCKED;
                LOCKED:  if (!w_pass_loss && (w_miss_inc >= C_MISS_MAX)) w_state_nxt = SEARCH;
                default: w_state_nxt = SEARCH;
            endcase
        end
    end

    always_comb begin
        locked = (r_state == LOCKED);
    end

    // A failed search window holds the local code back one chip on the next strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slip_pend <= 1'b0;
            r_slip_cnt  <= '0;
            r_miss      <= '0;
        end else begin
            if (w_win_end && (r_state == SEARCH) && !w_pass_lock) begin
                r_slip_pend <= 1'b1;
                r_slip_cnt  <= (r_slip_cnt == C_LAST) ? 5'd0 : r_slip_cnt + 5'd1;
            end else begin
                if (w_strobe) r_slip_pend <= 1'b0;
                if (w_enter_search) r_slip_cnt <= '0;
            end
            if (w_enter_locked || w_enter_search) begin
                r_miss <= '0;
            end else if (w_win_end && (r_state == LOCKED)) begin
                r_miss <= w_pass_loss ? 2'd0 : w_miss_inc;
            end
        end
    end

`ifdef MSYNC_BER_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_enter_locked) begin
            r_err_cnt <= '0;
        end else if (w_strobe && (r_state == LOCKED) && !w_match && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 16'd0;
`endif

    assign local_code = w_chip;
    assign corr_val   = r_corr_val;
    assign corr_valid = r_corr_valid;
    assign slip_cnt   = r_slip_cnt;

endmodule

// File: tb/tb_m_code_31_sync.sv
// tb/tb_m_code_31_sync.sv - scoreboard bench for m_code_31_sync: align, noise, phase, loss, offset, reset
module tb_m_code_31_sync;

`ifdef MSYNC_BER_EN
    localparam int BER_ON = 1;
`else
    localparam int BER_ON = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        rx_code;
    logic        locked;
    logic        local_code;
    logic [4:0]  corr_val;
    logic        corr_valid;
    logic [4:0]  slip_cnt;
    logic [15:0] err_cnt;

    typedef struct {
        int id;
        int kind;   // 0: exact corr, 1: corr below lock threshold, 2: corr at/above lock threshold
        int corr;
        int lk;
        int slip;
        int err;
    } exp_t;

    exp_t sb[$];
    bit   seq[31];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   win_no = 0;
    int   lat = 0;

    m_code_31_sync dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_code    (rx_code),
        .locked     (locked),
        .local_code (local_code),
        .corr_val   (corr_val),
        .corr_valid (corr_valid),
        .slip_cnt   (slip_cnt),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input int kind, input int corr, input int lk, input int slip, input int err);
        exp_t e;
        e.id   = win_no;
        e.kind = kind;
        e.corr = corr;
        e.lk   = lk;
        e.slip = slip;
        e.err  = err * BER_ON;
        sb.push_back(e);
        win_no++;
    endtask

    // Transmit nchip chips of the reference sequence starting at index off.
    task automatic drive(input int off, input int nchip, input int n_inv, input bit zero, input int stretch);
        for (int i = 0; i < nchip; i++) begin
            bit v;
            v = seq[(i + off) % 31];
            if (i < n_inv) v = ~v;
            if (zero) v = 1'b0;
            rx_code = v;
            repeat ((i == stretch) ? 19 : 16) @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_locked"}, int'(locked), 0);
        chk({pfx, "_local_code"}, int'(local_code), 1);
        chk({pfx, "_corr_val"}, int'(corr_val), 0);
        chk({pfx, "_corr_valid"}, int'(corr_valid), 0);
        chk({pfx, "_slip_cnt"}, int'(slip_cnt), 0);
        chk({pfx, "_err_cnt"}, int'(err_cnt), 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && corr_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_corr_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    case (e.kind)
                        0: chk($sformatf("w%0d_corr", e.id), int'(corr_val), e.corr);
                        1: chk($sformatf("w%0d_corr_below_lock", e.id), int'(corr_val < 5'd28), 1);
                        default: chk($sformatf("w%0d_corr_at_lock", e.id), int'(corr_val >= 5'd28), 1);
                    endcase
                    chk($sformatf("w%0d_locked", e.id), int'(locked), e.lk);
                    chk($sformatf("w%0d_slip_cnt", e.id), int'(slip_cnt), e.slip);
                    chk($sformatf("w%0d_err_cnt", e.id), int'(err_cnt), e.err);
                end
            end
        end
    end

    initial begin
        logic [4:0] q;
        q = 5'b11111;
        for (int i = 0; i < 31; i++) begin
            seq[i] = q[0];
            q = {q[3] ^ q[0], q[4:1]};
        end

        rst_n   = 1'b0;
        rx_code = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        rst_n = 1'b1;

        // Aligned acquisition, then noise, phase shift, loss and reacquire.
        push(0, 31, 1, 0, 0);   drive(0, 31, 0, 1'b0, -1);
        push(0, 26, 1, 0, 5);   drive(0, 31, 5, 1'b0, -1);
        push(0, 26, 1, 0, 10);  drive(0, 31, 5, 1'b0, -1);
        push(0, 31, 1, 0, 10);  drive(0, 31, 0, 1'b0, 10);
        push(0, 15, 1, 0, 26);  drive(0, 31, 0, 1'b1, -1);
        push(0, 15, 0, 0, 42);  drive(0, 31, 0, 1'b1, -1);
        push(0, 31, 1, 0, 0);   drive(0, 31, 0, 1'b0, -1);

        // Received stream lags the local code by 5 chips.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int w = 0; w < 5; w++) begin
            push(1, 0, 0, w + 1, 0);
            drive(26, 31, 0, 1'b0, -1);
        end
        push(2, 0, 1, 5, 0);
        drive(26, 31, 0, 1'b0, -1);

        // Reset 12 chips into a window while locked.
        drive(26, 12, 0, 1'b0, -1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(0, 31, 1, 0, 0);
        fork
            drive(0, 31, 0, 1'b0, -1);
            begin
                for (int c = 1; c <= 700; c++) begin
                    @(negedge clk);
                    if (corr_valid) begin
                        lat = c;
                        break;
                    end
                end
            end
        join
        chk("rst_first_window_latency_ok", int'((lat >= 470) && (lat <= 510)), 1);
        chk("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
